// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision divider.
//   FP_EXP_BIAS / FP_EXP_MAX : exponent bias and all-ones exponent
//   FP_QNAN / FP_PINF        : canonical quiet NaN and +infinity
//   ITERS                    : quotient bits produced by the mantissa divider
//   fp_div_state_e           : divider FSM states
//   fp_sign/fp_exp/fp_man    : field slice helpers
package fp_pkg;

   localparam int unsigned FP_EXP_BIAS = 127;
   localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
   localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
   localparam logic [31:0] FP_PINF     = 32'h7F800000;
   localparam int unsigned ITERS       = 26;

   typedef enum logic [1:0] {IDLE, DIV, RND} fp_div_state_e;

   function automatic logic fp_sign(input logic [31:0] x);
      return x[31];
   endfunction

   function automatic logic [7:0] fp_exp(input logic [31:0] x);
      return x[30:23];
   endfunction

   function automatic logic [22:0] fp_man(input logic [31:0] x);
      return x[22:0];
   endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// Radix-2 restoring divider for 24-bit significands, one quotient bit per step.
//   clk, reset_n : clock, asynchronous active-low reset
//   a, b         : dividend / divisor significands, captured on load
//   load         : initialise remainder to a and clear the quotient
//   step         : produce the next quotient bit (MSB first)
//   q            : quotient bits shifted in so far
//   r            : current partial remainder
module fp_div_mant_core (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [23:0] a,
   input  logic [23:0] b,
   input  logic        load,
   input  logic        step,
   output logic [25:0] q,
   output logic [24:0] r
);

   logic [24:0] rem_q;
   logic [23:0] b_q;
   logic [25:0] q_q;
   logic        first_q;
   logic [24:0] trial;
   logic [24:0] diff;
   logic        ge;

   // The first compare is against the unshifted dividend so that it yields the
   // integer bit of a/b; afterwards rem < b, so the doubled value fits 25 bits.
   always_comb begin
      trial = first_q ? rem_q : {rem_q[23:0], 1'b0};
      ge    = trial >= {1'b0, b_q};
      diff  = trial - {1'b0, b_q};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem_q   <= '0;
         b_q     <= '0;
         q_q     <= '0;
         first_q <= 1'b0;
      end else if (load) begin
         rem_q   <= {1'b0, a};
         b_q     <= b;
         q_q     <= '0;
         first_q <= 1'b1;
      end else if (step) begin
         rem_q   <= ge ? diff : trial;
         q_q     <= {q_q[24:0], ge};
         first_q <= 1'b0;
      end
   end

   assign q = q_q;
   assign r = rem_q;

endmodule

// File: rtl/ieee754_fp_div.sv
// Sequential IEEE-754 single-precision divider, result = dataa / datab.
// Flush-to-zero on denormal inputs and outputs, round-to-nearest-even.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : request, sampled only while busy is low
//   dataa, datab : dividend / divisor, captured on the accepting edge
//   busy         : high from the accepting edge until the done edge
//   done         : one-cycle pulse, result valid
//   result       : quotient, held until the next done
module ieee754_fp_div (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);
   import fp_pkg::*;

   fp_div_state_e     state;
   logic [4:0]        iter_q;
   logic              sign_q;
   logic signed [9:0] e_base_q;
   logic              special_q;
   logic [31:0]       spec_val_q;

   logic              sa, sb, s_res;
   logic [7:0]        ea, eb;
   logic [22:0]       ma, mb;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic              spec_hit;
   logic [31:0]       spec_val;
   logic signed [9:0] e_base;

   logic [25:0]       q;
   logic [24:0]       r;

   logic [22:0]       mant_raw, mant_rnd;
   logic              guard, sticky, inc, carry;
   logic signed [9:0] e_norm, e_rnd;
   logic [31:0]       pack_res;

   // Operand classification; exp==0 counts as zero, which flushes denormals.
   always_comb begin
      sa       = fp_sign(dataa);
      sb       = fp_sign(datab);
      ea       = fp_exp(dataa);
      eb       = fp_exp(datab);
      ma       = fp_man(dataa);
      mb       = fp_man(datab);
      s_res    = sa ^ sb;
      a_nan    = (ea == FP_EXP_MAX) && (ma != '0);
      b_nan    = (eb == FP_EXP_MAX) && (mb != '0);
      a_inf    = (ea == FP_EXP_MAX) && (ma == '0);
      b_inf    = (eb == FP_EXP_MAX) && (mb == '0);
      a_zero   = (ea == 8'd0);
      b_zero   = (eb == 8'd0);
      spec_hit = 1'b1;
      spec_val = FP_QNAN;
      if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
         spec_val = FP_QNAN;
      end else if (a_inf || b_zero) begin
         spec_val = {s_res, FP_PINF[30:0]};
      end else if (a_zero || b_inf) begin
         spec_val = {s_res, 31'd0};
      end else begin
         spec_hit = 1'b0;
      end
      e_base = $signed({2'b00, ea} - {2'b00, eb} + 10'(FP_EXP_BIAS));
   end

   fp_div_mant_core u_core (
      .clk     (clk),
      .reset_n (reset_n),
      .a       ({1'b1, ma}),
      .b       ({1'b1, mb}),
      .load    ((state == IDLE) && start),
      .step    (state == DIV),
      .q       (q),
      .r       (r)
   );

   // Normalise, round to nearest even and pack.
   always_comb begin
      if (q[25]) begin
         mant_raw = q[24:2];
         guard    = q[1];
         sticky   = q[0] | (|r);
         e_norm   = e_base_q;
      end else begin
         mant_raw = q[23:1];
         guard    = q[0];
         sticky   = |r;
         e_norm   = e_base_q - 10'sd1;
      end
      inc               = guard & (sticky | mant_raw[0]);
      {carry, mant_rnd} = {1'b0, mant_raw} + {23'd0, inc};
      e_rnd             = e_norm + (carry ? 10'sd1 : 10'sd0);
      if (e_rnd >= 10'sd255) begin
         pack_res = {sign_q, FP_PINF[30:0]};
      end else if (e_rnd <= 10'sd0) begin
         pack_res = {sign_q, 31'd0};
      end else begin
         pack_res = {sign_q, e_rnd[7:0], mant_rnd};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         iter_q     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         sign_q     <= 1'b0;
         e_base_q   <= '0;
         special_q  <= 1'b0;
         spec_val_q <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy       <= 1'b1;
                  sign_q     <= s_res;
                  e_base_q   <= e_base;
                  special_q  <= spec_hit;
                  spec_val_q <= spec_val;
                  iter_q     <= '0;
                  state      <= spec_hit ? RND : DIV;
               end
            end
            DIV: begin
               if (iter_q == 5'(ITERS - 1)) begin
                  iter_q <= '0;
                  state  <= RND;
               end else begin
                  iter_q <= iter_q + 5'd1;
               end
            end
            RND: begin
               result <= special_q ? spec_val_q : pack_res;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ieee754_fp_div.sv
module tb_ieee754_fp_div;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dataa = '0;
   logic [31:0] datab = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   ieee754_fp_div dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .dataa   (dataa),
      .datab   (datab),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } txn_t;

   txn_t sb_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Reference: exact integer quotient of the significands, then RNE by comparing
   // twice the remainder with the divisor.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic   s;
      int     ea, eb, e;
      bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      longint sig_a, sig_b, num, quo, rem;
      s      = a[31] ^ b[31];
      ea     = int'(a[30:23]);
      eb     = int'(b[30:23]);
      a_nan  = (ea == 255) && (a[22:0] != 0);
      b_nan  = (eb == 255) && (b[22:0] != 0);
      a_inf  = (ea == 255) && (a[22:0] == 0);
      b_inf  = (eb == 255) && (b[22:0] == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      if (a_nan || b_nan) return 32'h7FC00000;
      if ((a_inf && b_inf) || (a_zero && b_zero)) return 32'h7FC00000;
      if (a_inf || b_zero) return {s, 8'hFF, 23'd0};
      if (a_zero || b_inf) return {s, 31'd0};
      sig_a = longint'(a[22:0]) + (longint'(1) << 23);
      sig_b = longint'(b[22:0]) + (longint'(1) << 23);
      e     = ea - eb + 127;
      if (sig_a < sig_b) begin
         num = sig_a << 24;
         e   = e - 1;
      end else begin
         num = sig_a << 23;
      end
      quo = num / sig_b;
      rem = num % sig_b;
      if ((2 * rem > sig_b) || ((2 * rem == sig_b) && (quo % 2 == 1))) quo = quo + 1;
      if (quo == (longint'(1) << 24)) begin
         quo = longint'(1) << 23;
         e   = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      return {s, 8'(e), 23'(quo)};
   endfunction

   function automatic logic [31:0] rand_fp();
      int          c;
      logic [31:0] v;
      c = $urandom_range(0, 9);
      v = $urandom;
      case (c)
         0: begin
            case ($urandom_range(0, 8))
               0: v = 32'h00000000;
               1: v = 32'h80000000;
               2: v = 32'h7F800000;
               3: v = 32'hFF800000;
               4: v = 32'h7FC00000;
               5: v = 32'h00000001;
               6: v = 32'h807FFFFF;
               7: v = 32'h7F7FFFFF;
               default: v = 32'h00800000;
            endcase
         end
         1: v[30:23] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3))
                                                   : 8'($urandom_range(252, 255));
         2: ;
         default: v[30:23] = 8'($urandom_range(64, 190));
      endcase
      return v;
   endfunction

   // Scoreboard monitor: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (reset_n && done) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_done: got done with result %h, expected no done pulse", result);
         end else begin
            txn_t t;
            t = sb_q.pop_front();
            check($sformatf("div %h/%h", t.a, t.b), result, t.exp);
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: busy still 1 after 200 cycles, expected 0");
      end
   endtask

   // Drive start for one cycle from a negedge; returns on the following negedge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input bit push);
      txn_t t;
      dataa = a;
      datab = b;
      start = 1'b1;
      if (push) begin
         t.a = a;
         t.b = b;
         t.exp = exp;
         sb_q.push_back(t);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic latency(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input string name);
      int k;
      wait_idle();
      issue(a, b, exp, 1'b1);
      k = 1;
      while (!done && k < 60) begin
         @(negedge clk);
         k++;
      end
      check({"latency ", name}, 32'(k), 32'(exp_lat));
      check({"busy_at_done ", name}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      int          k;

      repeat (3) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset result", result, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      latency(32'h40C00000, 32'h40000000, 32'h40400000, 28, "6/2");
      latency(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, "1/3");
      latency(32'hBF800000, 32'h00000000, 32'hFF800000, 2, "-1/0");
      latency(32'h00000000, 32'h00000000, 32'h7FC00000, 2, "0/0");
      latency(32'h7F800000, 32'h7F800000, 32'h7FC00000, 2, "inf/inf");
      latency(32'h7F000000, 32'h3F000000, 32'h7F800000, 28, "overflow");
      latency(32'h00800000, 32'h40000000, 32'h00000000, 28, "underflow");

      // Starts during busy are ignored; a start in the done cycle is accepted.
      wait_idle();
      issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b1);
      repeat (4) @(negedge clk);
      issue(32'h7F000000, 32'h3F000000, 32'h0, 1'b0);
      repeat (4) @(negedge clk);
      issue(32'h40C00000, 32'h40000000, 32'h0, 1'b0);
      k = 0;
      while (!done && k < 60) begin
         @(negedge clk);
         k++;
      end
      check("handshake done seen", {31'd0, done}, 32'd1);
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);
      check("b2b accepted", {31'd0, busy}, 32'd1);
      wait_idle();

      // Reset in the middle of a divide abandons it.
      issue(32'h3F800000, 32'h40400000, 32'h0, 1'b0);
      repeat (11) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midreset busy", {31'd0, busy}, 32'd0);
      check("midreset done", {31'd0, done}, 32'd0);
      check("midreset result", result, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (35) @(negedge clk);
      latency(32'h40C00000, 32'h40000000, 32'h40400000, 28, "after_reset");

      for (int i = 0; i < 2000; i++) begin
         ra = rand_fp();
         rb = rand_fp();
         wait_idle();
         issue(ra, rb, ref_div(ra, rb), 1'b1);
      end

      k = 0;
      while (sb_q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
